// File: rtl/mic_stream_monitor.sv
// Passive handshake, packet-length and stall monitor for NCH stream links.
// It counts completed packets per link and raises sticky err, done and timeout flags.
module mic_stream_monitor #(
   parameter int NCH         = 3,
   parameter int DW          = 64,
   parameter int MAX_BEATS   = 9,
   parameter int STALL_LIMIT = 1024,
   parameter int TIMEOUT     = 100000,
   parameter int CW          = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCH-1:0]      TVALID,
   input  logic [NCH-1:0]      TREADY,
   input  logic [NCH*DW-1:0]   TDATA,
   input  logic [NCH-1:0]      TLAST,
   input  logic [15:0]         target,
   output logic [NCH*16-1:0]   pkt_count,
   output logic                err,
   output logic [CW-1:0]       err_chan,
   output logic [2:0]          err_code,
   output logic                done,
   output logic                timeout
);

   localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BEATS - 1);
   localparam logic [SW-1:0] STALL_SAT  = SW'(STALL_LIMIT);
   localparam logic [SW-1:0] STALL_FIRE = SW'(STALL_LIMIT - 1);
   localparam logic [31:0]   CYC_END    = 32'(TIMEOUT - 1);

   logic [NCH-1:0]          prev_valid;
   logic [NCH-1:0]          prev_ready;
   logic [NCH-1:0]          prev_last;
   logic [NCH*DW-1:0]       prev_data;
   logic [NCH-1:0][BW-1:0]  beat_cnt;
   logic [NCH-1:0][SW-1:0]  stall_cnt;
   logic [NCH-1:0][15:0]    pkt_cnt;
   logic [31:0]             cycle_cnt;

   logic [NCH-1:0]          beat;
   logic [NCH-1:0]          stalled;
   logic [NCH-1:0]          valid_drop;
   logic [NCH-1:0]          data_change;
   logic [NCH-1:0]          pkt_long;
   logic [NCH-1:0]          stall_hit;

   logic                    hit;
   logic [CW-1:0]           hit_chan;
   logic [2:0]              hit_code;
   logic                    all_done;

   for (genvar g = 0; g < NCH; g++) begin : g_link
      assign beat[g]        = TVALID[g] & TREADY[g];
      assign stalled[g]     = prev_valid[g] & ~prev_ready[g];
      assign valid_drop[g]  = stalled[g] & ~TVALID[g];
      assign data_change[g] = stalled[g] & TVALID[g] &
                              ((TDATA[g*DW +: DW] != prev_data[g*DW +: DW]) |
                               (TLAST[g] != prev_last[g]));
      assign pkt_long[g]    = beat[g] & ~TLAST[g] & (beat_cnt[g] == BEAT_MAX);
      assign stall_hit[g]   = TVALID[g] & ~TREADY[g] & (stall_cnt[g] == STALL_FIRE);
   end

   // Scan from the top link down so the lowest-indexed offender overwrites the rest.
   always_comb begin
      hit      = 1'b0;
      hit_chan = '0;
      hit_code = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (valid_drop[i] | data_change[i] | pkt_long[i] | stall_hit[i]) begin
            hit      = 1'b1;
            hit_chan = CW'(i);
            if (valid_drop[i])       hit_code = 3'd1;
            else if (data_change[i]) hit_code = 3'd2;
            else if (pkt_long[i])    hit_code = 3'd3;
            else                     hit_code = 3'd4;
         end
      end
   end

   always_comb begin
      all_done = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if ((pkt_cnt[i] < target) || (beat_cnt[i] != '0)) all_done = 1'b0;
      end
   end

   // Beat counters hold at the limit after an overlong packet; stall counters
   // saturate one past the firing point so a long stall reports only once.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_valid <= '0;
         prev_ready <= '0;
         prev_last  <= '0;
         prev_data  <= '0;
         beat_cnt   <= '0;
         stall_cnt  <= '0;
         pkt_cnt    <= '0;
      end else begin
         prev_valid <= TVALID;
         prev_ready <= TREADY;
         prev_last  <= TLAST;
         prev_data  <= TDATA;
         for (int i = 0; i < NCH; i++) begin
            if (beat[i]) begin
               if (TLAST[i]) begin
                  beat_cnt[i] <= '0;
                  if (pkt_cnt[i] != 16'hffff) pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
               end else if (beat_cnt[i] != BEAT_MAX) begin
                  beat_cnt[i] <= beat_cnt[i] + BW'(1);
               end
            end
            if (TVALID[i] && !TREADY[i]) begin
               if (stall_cnt[i] != STALL_SAT) stall_cnt[i] <= stall_cnt[i] + SW'(1);
            end else begin
               stall_cnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err       <= 1'b0;
         err_chan  <= '0;
         err_code  <= '0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         if (!err && hit) begin
            err      <= 1'b1;
            err_chan <= hit_chan;
            err_code <= hit_code;
         end
         if (!done && !timeout) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (all_done)                  done    <= 1'b1;
            else if (cycle_cnt == CYC_END) timeout <= 1'b1;
         end
      end
   end

   // The packed counter array already has link i at bits [i*16 +: 16].
   assign pkt_count = pkt_cnt;

endmodule
